// File: rtl/clock_set_sequencer_if.sv
// Button, current-value and set/overwrite signals between the clock-set editor
// and its surroundings (debouncers, clockwork, calendar, alarm unit).
interface clock_set_sequencer_if;
   logic        tick_1hz;
   logic        btn_time;
   logic        btn_date;
   logic        btn_alarm;
   logic        btn_up;
   logic        btn_down;
   logic        btn_next;
   logic        btn_cancel;
   logic [19:0] time_cur;
   logic [24:0] date_cur;
   logic [12:0] alarm_cur;
   logic [19:0] time_set;
   logic        time_ow;
   logic [24:0] date_set;
   logic        date_ow;
   logic [12:0] alarm_set;
   logic        alarm_ow;
   logic        editing;
   logic [1:0]  field;
   logic        blink;

   modport slave (
      input  tick_1hz, btn_time, btn_date, btn_alarm, btn_up, btn_down,
             btn_next, btn_cancel, time_cur, date_cur, alarm_cur,
      output time_set, time_ow, date_set, date_ow, alarm_set, alarm_ow,
             editing, field, blink
   );

   modport master (
      output tick_1hz, btn_time, btn_date, btn_alarm, btn_up, btn_down,
             btn_next, btn_cancel, time_cur, date_cur, alarm_cur,
      input  time_set, time_ow, date_set, date_ow, alarm_set, alarm_ow,
             editing, field, blink
   );
endinterface

// File: rtl/clock_set_sequencer.sv
// Button-driven BCD editor for time, date and alarm with one-cycle overwrite strobes.
// Optional edit timeout enabled by defining CLOCK_SET_SEQUENCER_TIMEOUT_EN.
module clock_set_sequencer #(
   parameter int unsigned TIMEOUT_S = 30
) (
   input logic                  clk,
   input logic                  rst,
   clock_set_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, E_TIME, E_DATE, E_ALRM} state_t;

   state_t      state, nxt_state;
   logic [1:0]  fld, nxt_fld;
   logic [5:0]  hr, nxt_hr;
   logic [6:0]  mn, nxt_mn;
   logic [7:0]  yr, nxt_yr;
   logic [4:0]  mon, nxt_mon;
   logic [5:0]  day, nxt_day;
   logic        commit_t, commit_d, commit_a;
   logic        any_btn, timeout, blink;
   logic [5:0]  dim, day_clamped;
   logic [7:0]  st_in, st_out;
   logic [6:0]  st_lo, st_hi;
   logic [19:0] time_set;
   logic [24:0] date_set;
   logic [12:0] alarm_set;
   logic        time_ow, date_ow, alarm_ow;

   function automatic logic [6:0] bcd2bin(input logic [7:0] v);
      return {3'b0, v[7:4]} * 7'd10 + {3'b0, v[3:0]};
   endfunction

   function automatic logic [7:0] bin2bcd(input logic [6:0] b);
      logic [6:0] t, o;
      t = b / 7'd10;
      o = b % 7'd10;
      return {t[3:0], o[3:0]};
   endfunction

   // Wrapping step done in binary so BCD carries/borrows come for free.
   function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [6:0] lo,
                                           input logic [6:0] hi, input logic up);
      logic [6:0] b, r;
      b = bcd2bin(v);
      if (up) r = (b >= hi) ? lo : b + 7'd1;
      else    r = (b <= lo) ? hi : b - 7'd1;
      return bin2bcd(r);
   endfunction

   // Years are 2000-2099, so divisibility by 4 alone decides February.
   function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic [7:0] y);
      logic [6:0] yb;
      yb = bcd2bin(y);
      case (m)
         5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
         5'h02:                      return (yb[1:0] == 2'd0) ? 6'h29 : 6'h28;
         default:                    return 6'h31;
      endcase
   endfunction

   assign any_btn     = bus.btn_cancel | bus.btn_next | bus.btn_up | bus.btn_down;
   assign dim         = days_in_month(mon, yr);
   assign day_clamped = (day > dim) ? dim : day;

`ifdef CLOCK_SET_SEQUENCER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_S + 1);
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk or posedge rst)
      if (rst)                          tcnt <= '0;
      else if (state == IDLE || any_btn) tcnt <= '0;
      else if (bus.tick_1hz)            tcnt <= tcnt + 1'b1;

   // A press in the terminal-tick cycle wins and restarts the count.
   assign timeout = (state != IDLE) && !any_btn && bus.tick_1hz &&
                    (tcnt == TW'(TIMEOUT_S - 1));
`else
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT_S == 0);
   assign timeout          = 1'b0;
`endif

   // Operand/range for the field being stepped.
   always_comb begin
      st_in = '0;
      st_lo = 7'd0;
      st_hi = 7'd23;
      if (state == E_DATE) begin
         case (fld)
            2'd0:    begin st_in = yr;             st_hi = 7'd99; end
            2'd1:    begin st_in = {3'b0, mon};    st_lo = 7'd1; st_hi = 7'd12; end
            default: begin st_in = {2'b0, day};    st_lo = 7'd1; st_hi = bcd2bin({2'b0, dim}); end
         endcase
      end else if (fld == 2'd0) begin
         st_in = {2'b0, hr};
      end else begin
         st_in = {1'b0, mn};
         st_hi = 7'd59;
      end
   end

   assign st_out = bcd_step(st_in, st_lo, st_hi, bus.btn_up);

   always_comb begin
      nxt_state = state;
      nxt_fld   = fld;
      nxt_hr    = hr;
      nxt_mn    = mn;
      nxt_yr    = yr;
      nxt_mon   = mon;
      nxt_day   = day;
      commit_t  = 1'b0;
      commit_d  = 1'b0;
      commit_a  = 1'b0;
      case (state)
         IDLE: begin
            nxt_fld = 2'd0;
            if (bus.btn_time) begin
               nxt_state = E_TIME;
               nxt_hr    = bus.time_cur[19:14];
               nxt_mn    = bus.time_cur[13:7];
            end else if (bus.btn_date) begin
               nxt_state = E_DATE;
               nxt_day   = bus.date_cur[24:19];
               nxt_mon   = bus.date_cur[18:14];
               nxt_yr    = bus.date_cur[7:0];
            end else if (bus.btn_alarm) begin
               nxt_state = E_ALRM;
               nxt_hr    = bus.alarm_cur[12:7];
               nxt_mn    = bus.alarm_cur[6:0];
            end
         end
         default: begin
            if (bus.btn_cancel || timeout) begin
               nxt_state = IDLE;
               nxt_fld   = 2'd0;
            end else if (bus.btn_next) begin
               if (fld == ((state == E_DATE) ? 2'd2 : 2'd1)) begin
                  nxt_state = IDLE;
                  nxt_fld   = 2'd0;
                  commit_t  = (state == E_TIME);
                  commit_d  = (state == E_DATE);
                  commit_a  = (state == E_ALRM);
               end else begin
                  nxt_fld = fld + 2'd1;
                  if (state == E_DATE && fld == 2'd1) nxt_day = day_clamped;
               end
            end else if (bus.btn_up || bus.btn_down) begin
               if (state == E_DATE) begin
                  case (fld)
                     2'd0:    nxt_yr  = st_out;
                     2'd1:    nxt_mon = st_out[4:0];
                     default: nxt_day = st_out[5:0];
                  endcase
               end else if (fld == 2'd0) begin
                  nxt_hr = st_out[5:0];
               end else begin
                  nxt_mn = st_out[6:0];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fld       <= 2'd0;
         blink     <= 1'b0;
         hr        <= '0;
         mn        <= '0;
         yr        <= '0;
         mon       <= '0;
         day       <= '0;
         time_set  <= 20'h0;
         date_set  <= {6'h01, 5'h01, 14'h0};
         alarm_set <= 13'h0;
         time_ow   <= 1'b0;
         date_ow   <= 1'b0;
         alarm_ow  <= 1'b0;
      end else begin
         state    <= nxt_state;
         fld      <= nxt_fld;
         hr       <= nxt_hr;
         mn       <= nxt_mn;
         yr       <= nxt_yr;
         mon      <= nxt_mon;
         day      <= nxt_day;
         blink    <= (state == IDLE || nxt_state == IDLE) ? 1'b0 : blink ^ bus.tick_1hz;
         time_ow  <= commit_t;
         date_ow  <= commit_d;
         alarm_ow <= commit_a;
         if (commit_t) time_set  <= {hr, mn, 7'h00};
         if (commit_d) date_set  <= {day_clamped, mon, 6'h00, yr};
         if (commit_a) alarm_set <= {hr, mn};
      end
   end

   assign bus.time_set  = time_set;
   assign bus.time_ow   = time_ow;
   assign bus.date_set  = date_set;
   assign bus.date_ow   = date_ow;
   assign bus.alarm_set = alarm_set;
   assign bus.alarm_ow  = alarm_ow;
   assign bus.editing   = (state != IDLE);
   assign bus.field     = fld;
   assign bus.blink     = blink;
endmodule

// File: tb/tb_clock_set_sequencer.sv
// Directed plus randomized bench for clock_set_sequencer against a decimal-level model.
module tb_clock_set_sequencer;
   localparam int TO = 3;
   localparam logic [6:0] BT = 7'h40, BD = 7'h20, BA = 7'h10, BU = 7'h08,
                          BDN = 7'h04, BN = 7'h02, BC = 7'h01;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clock_set_sequencer_if ifc();
   clock_set_sequencer #(.TIMEOUT_S(TO)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode 0 idle, 1 time, 2 date, 3 alarm; field values as plain integers.
   int m_mode, m_fld, m_blink, m_h, m_mi, m_y, m_mo, m_d, m_tc;
   logic [19:0] e_tset;
   logic [24:0] e_dset;
   logic [12:0] e_aset;
   logic e_tow, e_dow, e_aow;

   function automatic int b2i(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] i2b(input int i);
      return {4'(i / 10), 4'(i % 10)};
   endfunction

   function automatic int dim_of(input int mo, input int y);
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      if (mo == 2) return (y % 4 == 0) ? 29 : 28;
      return 31;
   endfunction

   function automatic int wrap(input int v, input int lo, input int hi, input bit up);
      if (up) return (v == hi) ? lo : v + 1;
      return (v == lo) ? hi : v - 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_fld = 0; m_blink = 0; m_tc = 0;
      e_tset = 20'h0; e_dset = {6'h01, 5'h01, 14'h0}; e_aset = 13'h0;
      e_tow = 0; e_dow = 0; e_aow = 0;
   endtask

   task automatic model_step();
      bit to, nb, up;
      int dm;
      e_tow = 0; e_dow = 0; e_aow = 0;
      if (m_mode == 0) begin
         m_blink = 0; m_fld = 0; m_tc = 0;
         if (ifc.btn_time) begin
            m_mode = 1; m_h = b2i({2'b0, ifc.time_cur[19:14]}); m_mi = b2i({1'b0, ifc.time_cur[13:7]});
         end else if (ifc.btn_date) begin
            m_mode = 2; m_d = b2i({2'b0, ifc.date_cur[24:19]});
            m_mo = b2i({3'b0, ifc.date_cur[18:14]}); m_y = b2i(ifc.date_cur[7:0]);
         end else if (ifc.btn_alarm) begin
            m_mode = 3; m_h = b2i({2'b0, ifc.alarm_cur[12:7]}); m_mi = b2i({1'b0, ifc.alarm_cur[6:0]});
         end
      end else begin
         to = 0;
         up = ifc.btn_up;
`ifdef CLOCK_SET_SEQUENCER_TIMEOUT_EN
         if (ifc.btn_cancel | ifc.btn_next | ifc.btn_up | ifc.btn_down) m_tc = 0;
         else if (ifc.tick_1hz) begin
            m_tc++;
            if (m_tc >= TO) to = 1;
         end
`endif
         nb = m_blink[0] ^ ifc.tick_1hz;
         dm = dim_of(m_mo, m_y);
         if (ifc.btn_cancel || to) m_mode = 0;
         else if (ifc.btn_next) begin
            if (m_fld == ((m_mode == 2) ? 2 : 1)) begin
               if (m_mode == 1) begin e_tow = 1; e_tset = {6'(i2b(m_h)), 7'(i2b(m_mi)), 7'h00}; end
               if (m_mode == 3) begin e_aow = 1; e_aset = {6'(i2b(m_h)), 7'(i2b(m_mi))}; end
               if (m_mode == 2) begin
                  if (m_d > dm) m_d = dm;
                  e_dow = 1; e_dset = {6'(i2b(m_d)), 5'(i2b(m_mo)), 6'h00, i2b(m_y)};
               end
               m_mode = 0;
            end else begin
               m_fld++;
               if (m_mode == 2 && m_fld == 2 && m_d > dm) m_d = dm;
            end
         end else if (ifc.btn_up || ifc.btn_down) begin
            if (m_mode == 2) begin
               if (m_fld == 0) m_y = wrap(m_y, 0, 99, up);
               else if (m_fld == 1) m_mo = wrap(m_mo, 1, 12, up);
               else m_d = wrap(m_d, 1, dm, up);
            end else if (m_fld == 0) m_h = wrap(m_h, 0, 23, up);
            else m_mi = wrap(m_mi, 0, 59, up);
         end
         if (m_mode == 0) begin m_blink = 0; m_fld = 0; end
         else m_blink = int'(nb);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("editing",   32'(ifc.editing),   32'(m_mode != 0));
      check("field",     32'(ifc.field),     32'(m_fld));
      check("blink",     32'(ifc.blink),     32'(m_blink));
      check("time_set",  32'(ifc.time_set),  32'(e_tset));
      check("time_ow",   32'(ifc.time_ow),   32'(e_tow));
      check("date_set",  32'(ifc.date_set),  32'(e_dset));
      check("date_ow",   32'(ifc.date_ow),   32'(e_dow));
      check("alarm_set", 32'(ifc.alarm_set), 32'(e_aset));
      check("alarm_ow",  32'(ifc.alarm_ow),  32'(e_aow));
   endtask

   task automatic step(input logic [6:0] b, input logic tk);
      @(negedge clk);
      {ifc.btn_time, ifc.btn_date, ifc.btn_alarm, ifc.btn_up, ifc.btn_down,
       ifc.btn_next, ifc.btn_cancel} = b;
      ifc.tick_1hz = tk;
      model_step();
      @(posedge clk);
      #1;
      check_all();
      {ifc.btn_time, ifc.btn_date, ifc.btn_alarm, ifc.btn_up, ifc.btn_down,
       ifc.btn_next, ifc.btn_cancel} = '0;
      ifc.tick_1hz = 1'b0;
   endtask

   task automatic repeat_step(input logic [6:0] b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0);
   endtask

   initial begin
      {ifc.btn_time, ifc.btn_date, ifc.btn_alarm, ifc.btn_up, ifc.btn_down,
       ifc.btn_next, ifc.btn_cancel} = '0;
      ifc.tick_1hz = 1'b0;
      ifc.time_cur = '0; ifc.date_cur = '0; ifc.alarm_cur = '0;
      model_reset();
      #12;
      check_all();
      @(negedge clk) rst = 1'b0;

      // Reset in the middle of a date edit, before any date commit.
      ifc.date_cur = {6'h15, 5'h06, 14'h47};
      step(BD, 1'b0);
      step(BN, 1'b0);
      check("mid_edit_field", 32'(ifc.field), 32'd1);
      @(negedge clk) rst = 1'b1;
      #1;
      model_reset();
      check_all();
      check("rst_date_set", 32'(ifc.date_set), 32'({6'h01, 5'h01, 14'h0}));
      @(negedge clk) rst = 1'b0;

      // Time edit: hour 12 +12 wraps to 00, min 34 -35 wraps to 59.
      ifc.time_cur = {6'h12, 7'h34, 7'h56};
      step(BT, 1'b0);
      repeat_step(BU, 12);
      step(BN, 1'b0);
      repeat_step(BDN, 35);
      step(BN, 1'b0);
      check("plan_time_ow",  32'(ifc.time_ow),  32'd1);
      check("plan_time_set", 32'(ifc.time_set), 32'({6'h00, 7'h59, 7'h00}));
      step(7'h0, 1'b0);
      check("time_ow_one_cycle", 32'(ifc.time_ow), 32'd0);

      // Leap year 00: Feb day 31 clamps to 29.
      ifc.date_cur = {6'h31, 5'h01, 14'h21};
      step(BD, 1'b0);
      repeat_step(BDN, 21);
      step(BN, 1'b0); step(BU, 1'b0); step(BN, 1'b0); step(BN, 1'b0);
      check("plan_leap_set", 32'(ifc.date_set), 32'({6'h29, 5'h02, 14'h00}));
      check("plan_leap_ow",  32'(ifc.date_ow),  32'd1);

      // Non-leap year 01: clamp to 28.
      ifc.date_cur = {6'h31, 5'h01, 14'h22};
      step(BD, 1'b0);
      repeat_step(BDN, 21);
      step(BN, 1'b0); step(BU, 1'b0); step(BN, 1'b0); step(BN, 1'b0);
      check("plan_nonleap_set", 32'(ifc.date_set), 32'({6'h28, 5'h02, 14'h01}));

      // Day 01 down wraps to 28 in a non-leap February.
      ifc.date_cur = {6'h01, 5'h02, 14'h05};
      step(BD, 1'b0); step(BN, 1'b0); step(BN, 1'b0); step(BDN, 1'b0); step(BN, 1'b0);
      check("day_wrap_set", 32'(ifc.date_set), 32'({6'h28, 5'h02, 14'h05}));

      // Alarm cancel then commit 07:30.
      ifc.alarm_cur = 13'h0;
      step(BA, 1'b0); step(BU, 1'b0); step(BC, 1'b0);
      check("alarm_cancel_ow",  32'(ifc.alarm_ow),  32'd0);
      check("alarm_cancel_set", 32'(ifc.alarm_set), 32'd0);
      step(BA, 1'b0);
      repeat_step(BU, 7);
      step(BN, 1'b0);
      repeat_step(BU, 30);
      step(BN, 1'b0);
      check("plan_alarm_set", 32'(ifc.alarm_set), 32'({6'h07, 7'h30}));

      // Priority: next beats up; date start ignored while editing time.
      ifc.time_cur = {6'h05, 7'h10, 7'h22};
      step(BT, 1'b0);
      step(BN | BU, 1'b0);
      check("next_over_up_field", 32'(ifc.field), 32'd1);
      step(BD, 1'b0);
      check("start_ignored", 32'(ifc.editing), 32'd1);
      step(BN, 1'b0);
      check("prio_time_set", 32'(ifc.time_set), 32'({6'h05, 7'h10, 7'h00}));
      ifc.time_cur = {6'h09, 7'h45, 7'h00};
      step(BT | BD, 1'b0); step(BN, 1'b0); step(BN, 1'b0);
      check("time_over_date_ow", 32'(ifc.time_ow), 32'd1);
      check("time_over_date_dow", 32'(ifc.date_ow), 32'd0);

`ifdef CLOCK_SET_SEQUENCER_TIMEOUT_EN
      step(BA, 1'b0);
      step(7'h0, 1'b1); step(7'h0, 1'b1); step(7'h0, 1'b1);
      check("timeout_editing", 32'(ifc.editing), 32'd0);
      check("timeout_ow",      32'(ifc.alarm_ow), 32'd0);
`endif

      // Randomized sessions against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [6:0] b;
         if (i % 17 == 0) begin
            ifc.time_cur  = {6'(i2b(int'($urandom_range(0, 23)))), 7'(i2b(int'($urandom_range(0, 59)))),
                             7'(i2b(int'($urandom_range(0, 59))))};
            ifc.date_cur  = {6'(i2b(int'($urandom_range(1, 31)))), 5'(i2b(int'($urandom_range(1, 12)))),
                             6'($urandom), i2b(int'($urandom_range(0, 99)))};
            ifc.alarm_cur = {6'(i2b(int'($urandom_range(0, 23)))), 7'(i2b(int'($urandom_range(0, 59))))};
         end
         for (int k = 0; k < 7; k++) b[k] = ($urandom_range(0, 6) == 0);
         if (b[0] && $urandom_range(0, 3) != 0) b[0] = 1'b0;
         step(b, ($urandom_range(0, 4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
